// File: rtl/mm_pkg.sv
// Shared types and sizing helpers for the matrix-vector multiply engine.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mm_state_t;

  localparam int MM_ROW_SEL_W = 32;

  // Accumulator width that holds one full pass of N signed products without overflow.
  function automatic int mm_acc_w(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/mm_mac_lane.sv
// One multiply-accumulate lane: owns a single signed accumulator register.
module mm_mac_lane #(
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod = a * b;
  assign acc    = r_acc;

  // Accumulator: clear wins over accumulate; the sum wraps modulo 2^ACC_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

endmodule

// File: rtl/mm_vec_engine.sv
// Signed N x N matrix times N-vector engine: N parallel MAC lanes, one column per cycle,
// start/busy/done handshake and a registered row-select read port.
module mm_vec_engine
  import mm_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = mm_acc_w(N, DW)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    wr_is_vec,
  input  logic [$clog2(N)-1:0]    wr_row,
  input  logic [$clog2(N)-1:0]    wr_col,
  input  logic signed [DW-1:0]    wr_data,
  input  logic                    acc_mode,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [MM_ROW_SEL_W-1:0] row_sel,
  output logic signed [ACC_W-1:0] row_out
);

  localparam int CW = $clog2(N);

  mm_state_t               r_state;
  mm_state_t               w_next;
  logic [CW-1:0]           r_col_cnt;
  logic signed [DW-1:0]    r_a [N][N];
  logic signed [DW-1:0]    r_v [N];
  logic signed [ACC_W-1:0] w_acc [N];
  logic signed [ACC_W-1:0] r_row_out;
  logic                    r_busy;
  logic                    r_done;
  logic                    w_run;
  logic                    w_go;
  logic                    w_clr;
  logic                    w_wr_ok;
  logic                    w_last;

  assign w_run   = (r_state == RUN);
  assign w_go    = (r_state == IDLE) && start;
  assign w_clr   = w_go && !acc_mode;
  assign w_wr_ok = wr_en && (r_state != RUN);
  assign w_last  = (r_col_cnt == CW'(N - 1));
  assign busy    = r_busy;
  assign done    = r_done;
  assign row_out = r_row_out;

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
        else       w_next = IDLE;
      end
      RUN: begin
        if (w_last) w_next = DONE;
        else        w_next = RUN;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register; busy/done are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == DONE);
    end
  end

  // Column counter walks 0..N-1 during RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_cnt <= '0;
    end else if (w_go || (w_run && w_last)) begin
      r_col_cnt <= '0;
    end else if (w_run) begin
      r_col_cnt <= r_col_cnt + CW'(1);
    end
  end

  // Operand storage; writes are locked out while a pass is running.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        r_v[r] <= '0;
        for (int c = 0; c < N; c++) begin
          r_a[r][c] <= '0;
        end
      end
    end else if (w_wr_ok) begin
      if (wr_is_vec) r_v[wr_col] <= wr_data;
      else           r_a[wr_row][wr_col] <= wr_data;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_lane
    mm_mac_lane #(
      .DW    (DW),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (w_clr),
      .en    (w_run),
      .a     (r_a[r][r_col_cnt]),
      .b     (r_v[r_col_cnt]),
      .acc   (w_acc[r])
    );
  end

  // Registered read port; out-of-range rows read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_out <= '0;
    end else if (row_sel < MM_ROW_SEL_W'(N)) begin
      r_row_out <= w_acc[row_sel[CW-1:0]];
    end else begin
      r_row_out <= '0;
    end
  end

endmodule

// File: tb/tb_mm_vec_engine.sv
// Self-checking bench for mm_vec_engine (N=4, DW=8, ACC_W=18): vector table, corner sequences, random vs model.
module tb_mm_vec_engine;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int ACC_W = 18;

  logic        clk = 1'b0;
  logic        reset, wr_en, wr_is_vec, acc_mode, start, busy, done;
  logic [1:0]  wr_row, wr_col;
  logic [7:0]  wr_data;
  logic [31:0] row_sel;
  logic [17:0] row_out;

  int n_tests = 0;
  int n_fail  = 0;

  longint m_a [4][4];
  longint m_v [4];
  longint m_acc [4];

  always #5 clk = ~clk;

  mm_vec_engine #(.N(N), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_is_vec (wr_is_vec),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .acc_mode  (acc_mode),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .row_sel   (row_sel),
    .row_out   (row_out)
  );

  typedef struct {
    int              fill;   // 0 keep matrix, 1 identity, 2 all -128
    logic [3:0][7:0] v;
    bit              mode;
    logic [3:0][17:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < N; r++) begin
      m_v[r] = 0;
      m_acc[r] = 0;
      for (int c = 0; c < N; c++) m_a[r][c] = 0;
    end
  endtask

  task automatic model_write(input bit vec, input int r, input int c, input logic [7:0] d);
    if (vec) m_v[c] = longint'($signed(d));
    else     m_a[r][c] = longint'($signed(d));
  endtask

  task automatic model_pass(input bit mode);
    for (int r = 0; r < N; r++) begin
      if (!mode) m_acc[r] = 0;
      for (int c = 0; c < N; c++) m_acc[r] += m_a[r][c] * m_v[c];
    end
  endtask

  task automatic do_write(input bit vec, input int r, input int c, input logic [7:0] d);
    wr_en = 1'b1; wr_is_vec = vec; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
    tick();
    wr_en = 1'b0;
    model_write(vec, r, c, d);
  endtask

  // One pass with handshake checks; optionally a write on the same edge as start.
  task automatic run_pass(input bit mode, input bit cw, input bit vec, input int r, input int c,
                          input logic [7:0] d, input string tag);
    int dones = 0;
    start = 1'b1; acc_mode = mode;
    if (cw) begin
      wr_en = 1'b1; wr_is_vec = vec; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
      model_write(vec, r, c, d);
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk({tag, " busy_run"}, 64'(busy), 64'd1);
      if (done) dones++;
      tick();
    end
    chk({tag, " busy_done"}, 64'(busy), 64'd0);
    chk({tag, " done_pulse"}, 64'(done), 64'd1);
    tick();
    chk({tag, " done_drop"}, 64'(done), 64'd0);
    chk({tag, " early_done"}, 64'(dones), 64'd0);
    model_pass(mode);
  endtask

  task automatic read_chk(input int r, input logic [17:0] exp, input string tag);
    row_sel = 32'(r);
    tick();
    chk(tag, 64'(row_out), 64'(exp));
  endtask

  task automatic check_model(input string tag);
    for (int r = 0; r < N; r++) begin
      logic [63:0] full;
      full = 64'(m_acc[r]);
      read_chk(r, full[17:0], tag);
    end
  endtask

  vec_t tbl [6];

  initial begin
    int dones;
    int nwr;
    logic [31:0] rnd;

    tbl[0] = '{1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, {18'd4, 18'd3, 18'd2, 18'd1}};
    tbl[1] = '{0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, {18'd8, 18'd6, 18'd4, 18'd2}};
    tbl[2] = '{0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, {18'd4, 18'd3, 18'd2, 18'd1}};
    tbl[3] = '{2, {8'h80, 8'h80, 8'h80, 8'h80}, 1'b0, {18'h10000, 18'h10000, 18'h10000, 18'h10000}};
    tbl[4] = '{0, {8'h80, 8'h80, 8'h80, 8'h80}, 1'b1, {18'h20000, 18'h20000, 18'h20000, 18'h20000}};
    tbl[5] = '{1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, {18'd4, 18'd3, 18'd2, 18'd1}};

    reset = 1'b1; wr_en = 1'b0; wr_is_vec = 1'b0; wr_row = 2'd0; wr_col = 2'd0;
    wr_data = 8'd0; acc_mode = 1'b0; start = 1'b0; row_sel = 32'd0;
    model_clear();
    tick(); tick();
    reset = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset row_out", 64'(row_out), 64'd0);

    // Table-driven passes
    for (int t = 0; t < 6; t++) begin
      if (tbl[t].fill != 0) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            do_write(1'b0, r, c, (tbl[t].fill == 1) ? ((r == c) ? 8'd1 : 8'd0) : 8'h80);
      end
      for (int c = 0; c < N; c++) do_write(1'b1, 0, c, tbl[t].v[c]);
      run_pass(tbl[t].mode, 1'b0, 1'b0, 0, 0, 8'd0, $sformatf("tbl%0d", t));
      for (int r = 0; r < N; r++) read_chk(r, tbl[t].exp[r], $sformatf("tbl%0d row%0d", t, r));
    end

    // Out-of-range reads and read latency
    read_chk(7, 18'd0, "rowsel 7");
    read_chk(4, 18'd0, "rowsel N");
    read_chk(-1, 18'd0, "rowsel ffffffff");
    row_sel = 32'd2;
    #1;
    chk("rowsel latency before edge", 64'(row_out), 64'd0);
    tick();
    chk("rowsel 2", 64'(row_out), 64'd3);

    // Write and start during RUN are ignored; start in DONE is ignored
    dones = 0;
    start = 1'b1; acc_mode = 1'b0;
    tick();
    start = 1'b0;
    tick();
    wr_en = 1'b1; wr_is_vec = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd5; start = 1'b1;
    for (int k = 0; k < N - 1; k++) begin
      if (done) dones++;
      tick();
    end
    wr_en = 1'b0;
    if (done) dones++;
    tick();
    start = 1'b0;
    chk("start in DONE ignored", 64'(busy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      if (done) dones++;
      tick();
    end
    chk("single done", 64'(dones), 64'd1);
    model_pass(1'b0);
    check_model("run-locked pass");
    run_pass(1'b0, 1'b0, 1'b0, 0, 0, 8'd0, "recheck");
    check_model("A00 unchanged");

    // Reset in the middle of a pass
    start = 1'b1; acc_mode = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    chk("midrun reset busy", 64'(busy), 64'd0);
    chk("midrun reset done", 64'(done), 64'd0);
    chk("midrun reset row_out", 64'(row_out), 64'd0);
    dones = 0;
    for (int k = 0; k < N + 2; k++) begin
      if (done || busy) dones++;
      tick();
    end
    chk("no done after reset", 64'(dones), 64'd0);
    check_model("acc zero after reset");
    for (int c = 0; c < N; c++) do_write(1'b1, 0, c, 8'd1);
    run_pass(1'b1, 1'b0, 1'b0, 0, 0, 8'd0, "matrix cleared");
    check_model("matrix cleared rows");

    // Randomized passes against the model
    for (int it = 0; it < 25; it++) begin
      nwr = $urandom_range(0, 6);
      for (int w = 0; w < nwr; w++) begin
        rnd = $urandom;
        do_write(rnd[0], int'(rnd[2:1]), int'(rnd[4:3]), rnd[15:8]);
      end
      rnd = $urandom;
      run_pass(rnd[1:0] != 2'd0, rnd[2], rnd[3], int'(rnd[5:4]), int'(rnd[7:6]), rnd[15:8],
               $sformatf("rnd%0d", it));
      check_model($sformatf("rnd%0d rows", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
